// File: rtl/mpw_io_arbiter.sv
// mpw_io_arbiter: shares the user IO pads between NPROJ wrapped projects.
// A request on 'active' is synchronized, all pads are tristated for a guard
// interval, then the new owner is granted the pads while still held in reset
// for RST_HOLD cycles before it is released to run.
//
// Optional build macro MPW_ARB_CONFLICT_CNT_EN adds an 8-bit saturating
// counter of cycles with more than one synchronized request.
module mpw_io_arbiter #(
  parameter int unsigned NPROJ        = 4,
  parameter int unsigned IO_W         = 38,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned GUARD_CYCLES = 4,
  parameter int unsigned RST_HOLD     = 8
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic [NPROJ-1:0]        active,
  input  logic [NPROJ*IO_W-1:0]   proj_io_out,
  input  logic [NPROJ*IO_W-1:0]   proj_io_oeb,
  output logic [IO_W-1:0]         io_out,
  output logic [IO_W-1:0]         io_oeb,
  output logic [NPROJ-1:0]        grant,
  output logic [NPROJ-1:0]        proj_rst,
  output logic                    switching,
`ifdef MPW_ARB_CONFLICT_CNT_EN
  output logic [7:0]              conflict_cnt,
`endif
  output logic                    conflict
);

  localparam int unsigned CW     = (NPROJ > 1) ? $clog2(NPROJ) : 1;
  localparam int unsigned MAXC   = (GUARD_CYCLES > RST_HOLD) ? GUARD_CYCLES : RST_HOLD;
  localparam int unsigned CNT_W  = $clog2(MAXC) + 1;

  localparam logic [CNT_W-1:0] GUARD_LOAD = CNT_W'(GUARD_CYCLES - 1);
  localparam logic [CNT_W-1:0] RST_LOAD   = CNT_W'(RST_HOLD - 1);

  typedef enum logic [1:0] {
    StNone,
    StGuard,
    StReset,
    StRun
  } state_t;

  state_t              state;
  logic [CW-1:0]       cur;
  logic [CNT_W-1:0]    cnt;

  logic [NPROJ-1:0]    sync [SYNC_STAGES];
  logic [NPROJ-1:0]    act_s;

  logic [CW-1:0]       tgt;
  logic                tgt_valid;
  logic                multi;
  logic                to_none;

  logic [IO_W-1:0]     out_slice [NPROJ];
  logic [IO_W-1:0]     oeb_slice [NPROJ];

  assign act_s = sync[SYNC_STAGES-1];

  // Request synchronizer: 'active' comes from another clock domain.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync[i] <= '0;
      end
    end else begin
      sync[0] <= active;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync[i] <= sync[i-1];
      end
    end
  end

  // Target selection: lowest set synchronized request wins.
  always_comb begin
    tgt       = '0;
    tgt_valid = 1'b0;
    for (int i = NPROJ - 1; i >= 0; i--) begin
      if (act_s[i]) begin
        tgt       = CW'(i);
        tgt_valid = 1'b1;
      end
    end
  end

  // More than one request pending: clearing the lowest set bit leaves something.
  assign multi   = |(act_s & (act_s - NPROJ'(1)));
  assign to_none = (state != StNone) && !tgt_valid;

  // Unpack the per-project pad buses so the mux can index by owner.
  for (genvar p = 0; p < NPROJ; p++) begin : g_slice
    assign out_slice[p] = proj_io_out[p*IO_W +: IO_W];
    assign oeb_slice[p] = proj_io_oeb[p*IO_W +: IO_W];
  end

  // Ownership FSM with registered grant, project resets and conflict flag.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state    <= StNone;
      cur      <= '0;
      cnt      <= '0;
      grant    <= '0;
      proj_rst <= '1;
      conflict <= 1'b0;
    end else begin
      conflict <= multi;
      unique case (state)
        StNone: begin
          if (tgt_valid) begin
            state <= StGuard;
            cur   <= tgt;
            cnt   <= GUARD_LOAD;
          end
        end
        StGuard: begin
          if (!tgt_valid) begin
            state <= StNone;
          end else if (tgt != cur) begin
            // Request moved while tristated: start the guard over for the new owner.
            cur <= tgt;
            cnt <= GUARD_LOAD;
          end else if (cnt == '0) begin
            state <= StReset;
            grant <= NPROJ'(1) << cur;
            cnt   <= RST_LOAD;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        StReset: begin
          if (!tgt_valid) begin
            state <= StNone;
            grant <= '0;
          end else if (tgt != cur) begin
            state <= StGuard;
            grant <= '0;
            cur   <= tgt;
            cnt   <= GUARD_LOAD;
          end else if (cnt == '0) begin
            state    <= StRun;
            proj_rst <= ~(NPROJ'(1) << cur);
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        StRun: begin
          if (!tgt_valid) begin
            state    <= StNone;
            grant    <= '0;
            proj_rst <= '1;
          end else if (tgt != cur) begin
            state    <= StGuard;
            grant    <= '0;
            proj_rst <= '1;
            cur      <= tgt;
            cnt      <= GUARD_LOAD;
          end
        end
        default: begin
          state    <= StNone;
          grant    <= '0;
          proj_rst <= '1;
        end
      endcase
    end
  end

  assign switching = (state == StGuard) || (state == StReset);

  // Pad mux straight from registered state so an async reset tristates at once.
  always_comb begin
    io_out = '0;
    io_oeb = '1;
    if ((state == StReset) || (state == StRun)) begin
      io_out = out_slice[cur];
      io_oeb = oeb_slice[cur];
    end
  end

`ifdef MPW_ARB_CONFLICT_CNT_EN
  // Saturating count of conflict cycles, restarted whenever the arbiter goes idle.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      conflict_cnt <= '0;
    end else if (to_none) begin
      conflict_cnt <= '0;
    end else if (conflict && (conflict_cnt != 8'hFF)) begin
      conflict_cnt <= conflict_cnt + 8'd1;
    end
  end
`else
  // Without the conflict counter the idle-entry strobe has no consumer.
  logic unused_to_none;
  assign unused_to_none = to_none;
`endif

endmodule

// File: tb/tb_mpw_io_arbiter.sv
// Bench for mpw_io_arbiter: vector table driven through a scoreboard queue
// plus hand-written power-on, guard-restart, async-reset and pulse sequences.
module tb_mpw_io_arbiter;

  localparam int NPROJ = 4;
  localparam int IO_W  = 38;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NPROJ-1:0]      active = 4'b0001;
  logic [NPROJ*IO_W-1:0] proj_io_out;
  logic [NPROJ*IO_W-1:0] proj_io_oeb;
  logic [IO_W-1:0]       io_out;
  logic [IO_W-1:0]       io_oeb;
  logic [NPROJ-1:0]      grant;
  logic [NPROJ-1:0]      proj_rst;
  logic                  switching;
  logic                  conflict;
`ifdef MPW_ARB_CONFLICT_CNT_EN
  logic [7:0]            conflict_cnt;
`endif

  int passed = 0;
  int total  = 0;

  mpw_io_arbiter dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .active      (active),
    .proj_io_out (proj_io_out),
    .proj_io_oeb (proj_io_oeb),
    .io_out      (io_out),
    .io_oeb      (io_oeb),
    .grant       (grant),
    .proj_rst    (proj_rst),
    .switching   (switching),
`ifdef MPW_ARB_CONFLICT_CNT_EN
    .conflict_cnt(conflict_cnt),
`endif
    .conflict    (conflict)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] act;
    int         wait_n;
    logic [3:0] g;
    logic [3:0] r;
    logic       sw;
    logic       cf;
    int         owner;
    string      name;
  } vec_t;

  vec_t vecs[13];
  vec_t sbq[$];
  vec_t e;

  // Distinct, nonzero pad pattern per project.
  function automatic logic [IO_W-1:0] pat(input int p);
    logic [IO_W-1:0] v;
    v        = '0;
    v[7:0]   = 8'(160 + p);
    v[20:13] = 8'(3 * p + 1);
    v[37:30] = 8'(80 + p);
    return v;
  endfunction

  function automatic vec_t mk(input logic [3:0] a, input int n, input logic [3:0] g,
                              input logic [3:0] r, input logic sw, input logic cf,
                              input int own, input string nm);
    vec_t v;
    v.act = a; v.wait_n = n; v.g = g; v.r = r; v.sw = sw; v.cf = cf;
    v.owner = own; v.name = nm;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", name, got, exp);
    else passed++;
  endtask

  task automatic check_pads(input string tag, input int owner);
    logic [IO_W-1:0] eo;
    logic [IO_W-1:0] eb;
    if (owner < 0) begin
      eo = '0;
      eb = '1;
    end else begin
      eo = pat(owner);
      eb = ~pat(owner);
    end
    check({tag, " io_out"}, 64'(io_out), 64'(eo));
    check({tag, " io_oeb"}, 64'(io_oeb), 64'(eb));
  endtask

  task automatic check_state(input string tag, input logic [3:0] g, input logic [3:0] r,
                             input logic sw, input int owner);
    check({tag, " grant"}, 64'(grant), 64'(g));
    check({tag, " proj_rst"}, 64'(proj_rst), 64'(r));
    check({tag, " switching"}, 64'(switching), 64'(sw));
    check_pads(tag, owner);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "timeout");
  end

  initial begin
    for (int p = 0; p < NPROJ; p++) begin
      proj_io_out[p*IO_W +: IO_W] = pat(p);
      proj_io_oeb[p*IO_W +: IO_W] = ~pat(p);
    end

    // Sequence continues from RUN with owner 0; waits are edges after the drive.
    vecs[0]  = mk(4'b0100, 2, 4'b0001, 4'b1110, 1'b0, 1'b0,  0, "sw_presync");
    vecs[1]  = mk(4'b0100, 1, 4'b0000, 4'b1111, 1'b1, 1'b0, -1, "sw_guard_first");
    vecs[2]  = mk(4'b0100, 3, 4'b0000, 4'b1111, 1'b1, 1'b0, -1, "sw_guard_last");
    vecs[3]  = mk(4'b0100, 1, 4'b0100, 4'b1111, 1'b1, 1'b0,  2, "sw_reset");
    vecs[4]  = mk(4'b0100, 7, 4'b0100, 4'b1111, 1'b1, 1'b0,  2, "sw_reset_last");
    vecs[5]  = mk(4'b0100, 1, 4'b0100, 4'b1011, 1'b0, 1'b0,  2, "sw_run");
    vecs[6]  = mk(4'b0110, 3, 4'b0000, 4'b1111, 1'b1, 1'b1, -1, "cf_guard");
    vecs[7]  = mk(4'b0110, 4, 4'b0010, 4'b1111, 1'b1, 1'b1,  1, "cf_reset");
    vecs[8]  = mk(4'b0110, 8, 4'b0010, 4'b1101, 1'b0, 1'b1,  1, "cf_run");
    vecs[9]  = mk(4'b0000, 3, 4'b0000, 4'b1111, 1'b0, 1'b0, -1, "drop_run");
    vecs[10] = mk(4'b0001, 7, 4'b0001, 4'b1111, 1'b1, 1'b0,  0, "req_reset");
    vecs[11] = mk(4'b0000, 2, 4'b0001, 4'b1111, 1'b1, 1'b0,  0, "drop_presync");
    vecs[12] = mk(4'b0000, 1, 4'b0000, 4'b1111, 1'b0, 1'b0, -1, "drop_reset");

    // Power-on: outputs safe throughout reset, then the default timing.
    for (int c = 0; c < 3; c++) begin
      tick();
      check_state($sformatf("por_hold%0d", c), 4'b0000, 4'b1111, 1'b0, -1);
      check("por_hold conflict", 64'(conflict), 64'(0));
    end
    rst = 1'b0;
    for (int ed = 1; ed <= 15; ed++) begin
      tick();
      if (ed == 2)  check_state("por_e2", 4'b0000, 4'b1111, 1'b0, -1);
      if (ed == 3)  check_state("por_e3", 4'b0000, 4'b1111, 1'b1, -1);
      if (ed == 6)  check_state("por_e6", 4'b0000, 4'b1111, 1'b1, -1);
      if (ed == 7)  check_state("por_e7", 4'b0001, 4'b1111, 1'b1,  0);
      if (ed == 14) check_state("por_e14", 4'b0001, 4'b1111, 1'b1, 0);
      if (ed == 15) check_state("por_e15", 4'b0001, 4'b1110, 1'b0, 0);
    end

    // Table vectors through the scoreboard.
    for (int i = 0; i < 13; i++) begin
      active = vecs[i].act;
      sbq.push_back(vecs[i]);
      repeat (vecs[i].wait_n) tick();
      e = sbq.pop_front();
      check_state(e.name, e.g, e.r, e.sw, e.owner);
      check({e.name, " conflict"}, 64'(conflict), 64'(e.cf));
    end

    // Guard restart: request moves to project 3 while guarding for project 0.
    active = 4'b0001;
    for (int ed = 1; ed <= 18; ed++) begin
      tick();
      if (ed == 3) active = 4'b1000;
      if (ed >= 3 && ed <= 9)
        check_state($sformatf("restart_e%0d", ed), 4'b0000, 4'b1111, 1'b1, -1);
      if (ed == 10) check_state("restart_grant", 4'b1000, 4'b1111, 1'b1, 3);
      if (ed == 18) check_state("restart_run", 4'b1000, 4'b0111, 1'b0, 3);
    end

    // Asynchronous reset between edges while running.
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_state("async_rst", 4'b0000, 4'b1111, 1'b0, -1);
    tick();
    rst    = 1'b0;
    active = 4'b0000;

    // Single-cycle pulse still captured: one guard cycle, then idle again.
    tick();
    active = 4'b0010;
    tick();
    active = 4'b0000;
    tick();
    tick();
    check_state("pulse_guard", 4'b0000, 4'b1111, 1'b1, -1);
    tick();
    check_state("pulse_drop", 4'b0000, 4'b1111, 1'b0, -1);

`ifdef MPW_ARB_CONFLICT_CNT_EN
    active = 4'b0110;
    repeat (300) tick();
    check("cnt_saturate", 64'(conflict_cnt), 64'(255));
    active = 4'b0000;
    repeat (3) tick();
    check("cnt_clear", 64'(conflict_cnt), 64'(0));
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
